// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding,
// control-bit positions and default field widths.
package pipe_pkg;

    // Occupancy of the stage: nothing held, main only, main plus skid.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    // Meaning of the low control bits; higher bits travel through untouched.
    localparam int unsigned REGWRITE_BIT = 0;
    localparam int unsigned MEMTOREG_BIT = 1;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_RD_W   = 5;
    localparam int unsigned DEF_CTRL_W = 2;
    localparam int unsigned DEF_CNT_W  = 16;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry {rdata, result, ctrl, rd}: loads when en_i is high,
// otherwise holds; cleared to zero by the asynchronous active-low reset.
module pipe_entry_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned CTRL_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [RD_W-1:0]   rd_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [DATA_W-1:0] result_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [RD_W-1:0]   rd_o
);

    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] result_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [RD_W-1:0]   rd_q;

    // Enable-loaded storage of the entry fields.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q  <= '0;
            result_q <= '0;
            ctrl_q   <= '0;
            rd_q     <= '0;
        end else if (en_i) begin
            rdata_q  <= rdata_i;
            result_q <= result_i;
            ctrl_q   <= ctrl_i;
            rd_q     <= rd_i;
        end
    end

    assign rdata_o  = rdata_q;
    assign result_o = result_q;
    assign ctrl_o   = ctrl_q;
    assign rd_o     = rd_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register. SKID=1 gives a two-entry skid stage
// with a registered in_ready; SKID=0 gives a single stall register whose
// in_ready follows out_ready combinationally. Also counts bubble cycles.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_W   = DEF_RD_W,
    parameter int unsigned CTRL_W = DEF_CTRL_W,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic [DATA_W-1:0] in_result,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic [DATA_W-1:0] out_result,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    output logic [CNT_W-1:0]  bubble_cnt
);

    state_e state_q, state_d;
    logic   rdy_q;
    logic   xfer_in, xfer_out;
    logic   main_en, skid_en, main_from_skid;
    logic [CNT_W-1:0] bubble_cnt_q;

    logic [DATA_W-1:0] main_rdata, main_result, skid_rdata, skid_result;
    logic [DATA_W-1:0] main_rdata_d, main_result_d;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
    logic [RD_W-1:0]   main_rd, skid_rd, main_rd_d;

    assign xfer_in  = in_valid & in_ready & ~flush;
    assign xfer_out = out_valid & out_ready;

    // State register plus the registered in_ready used by the skid variant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StEmpty;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != StTwo);
        end
    end

    // Next state and entry-register load enables; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (xfer_in) begin
                        state_d = StOne;
                        main_en = 1'b1;
                    end
                end
                StOne: begin
                    if (xfer_in && xfer_out) begin
                        main_en = 1'b1;
                    end else if (xfer_in) begin
                        // Only reachable with SKID=1: without it in_ready
                        // implies out_ready while main is occupied.
                        state_d = StTwo;
                        skid_en = 1'b1;
                    end else if (xfer_out) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (xfer_out) begin
                        state_d        = StOne;
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // Outputs: valid from occupancy, ctrl gated so bubbles never write back.
    always_comb begin
        out_valid = (state_q != StEmpty);
        in_ready  = (SKID != 0) ? rdy_q : (~out_valid | out_ready);
        out_ctrl  = out_valid ? main_ctrl : '0;
    end

    // Main loads from the skid entry when draining TWO, else from upstream.
    always_comb begin
        main_rdata_d  = main_from_skid ? skid_rdata  : in_rdata;
        main_result_d = main_from_skid ? skid_result : in_result;
        main_ctrl_d   = main_from_skid ? skid_ctrl   : in_ctrl;
        main_rd_d     = main_from_skid ? skid_rd     : in_rd;
    end

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk_i    (clk),
        .rst_ni   (reset),
        .en_i     (main_en),
        .rdata_i  (main_rdata_d),
        .result_i (main_result_d),
        .ctrl_i   (main_ctrl_d),
        .rd_i     (main_rd_d),
        .rdata_o  (main_rdata),
        .result_o (main_result),
        .ctrl_o   (main_ctrl),
        .rd_o     (main_rd)
    );

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk_i    (clk),
        .rst_ni   (reset),
        .en_i     (skid_en),
        .rdata_i  (in_rdata),
        .result_i (in_result),
        .ctrl_i   (in_ctrl),
        .rd_i     (in_rd),
        .rdata_o  (skid_rdata),
        .result_o (skid_result),
        .ctrl_o   (skid_ctrl),
        .rd_o     (skid_rd)
    );

    assign out_rdata  = main_rdata;
    assign out_result = main_result;
    assign out_rd     = main_rd;

    // Saturating count of cycles with no valid output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt_q <= '0;
        end else if (!out_valid && (bubble_cnt_q != '1)) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
    end

    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share stimulus and
// are each compared every cycle against a capacity-limited FIFO model.
module tb_pipe_stage_reg;

    localparam int CNTMAX = 15;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] result;
        logic [1:0]  ctrl;
        logic [4:0]  rd;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_rdata, in_result;
    logic [1:0]  in_ctrl;
    logic [4:0]  in_rd;

    logic        s1_in_ready, s1_out_valid, s0_in_ready, s0_out_valid;
    logic [31:0] s1_rdata, s1_result, s0_rdata, s0_result;
    logic [1:0]  s1_ctrl, s0_ctrl;
    logic [4:0]  s1_rd, s0_rd;
    logic [3:0]  s1_bub, s0_bub;

    int checks = 0;
    int errors = 0;

    // Model: index 0 = SKID=1 instance (capacity 2), index 1 = SKID=0 (capacity 1).
    ent_t fifo [2][2];
    int   occ  [2];
    ent_t last [2];
    int   bub  [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .RD_W(5), .CTRL_W(2), .SKID(1), .CNT_W(4)) dut_skid (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s1_in_ready),
        .in_rdata(in_rdata), .in_result(in_result), .in_ctrl(in_ctrl), .in_rd(in_rd),
        .out_valid(s1_out_valid), .out_ready(out_ready), .out_rdata(s1_rdata),
        .out_result(s1_result), .out_ctrl(s1_ctrl), .out_rd(s1_rd), .bubble_cnt(s1_bub)
    );

    pipe_stage_reg #(.DATA_W(32), .RD_W(5), .CTRL_W(2), .SKID(0), .CNT_W(4)) dut_stall (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s0_in_ready),
        .in_rdata(in_rdata), .in_result(in_result), .in_ctrl(in_ctrl), .in_rd(in_rd),
        .out_valid(s0_out_valid), .out_ready(out_ready), .out_rdata(s0_rdata),
        .out_result(s0_result), .out_ctrl(s0_ctrl), .out_rd(s0_rd), .bubble_cnt(s0_bub)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready(input int k);
        if (k == 0) return occ[0] < 2;
        return (occ[1] == 0) || out_ready;
    endfunction

    function automatic ent_t mk(input int v);
        ent_t e;
        e.rdata  = 32'hA000_0000 + v;
        e.result = v;
        e.ctrl   = 2'(v);
        e.rd     = 5'(v);
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        ent_t e;
        e.rdata  = $urandom;
        e.result = $urandom;
        e.ctrl   = 2'($urandom);
        e.rd     = 5'($urandom);
        return e;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            occ[k]  = 0;
            last[k] = '0;
            bub[k]  = 0;
        end
    endtask

    task automatic check_all();
        ent_t exp_e;
        for (int k = 0; k < 2; k++) begin
            exp_e = (occ[k] > 0) ? fifo[k][0] : last[k];
            if (occ[k] == 0) exp_e.ctrl = 2'b00;
            if (k == 0) begin
                chk("skid.out_valid", 128'(s1_out_valid), 128'(occ[0] > 0));
                chk("skid.in_ready", 128'(s1_in_ready), 128'(model_ready(0)));
                chk("skid.entry", 128'({s1_rdata, s1_result, s1_ctrl, s1_rd}), 128'(exp_e));
                chk("skid.bubble_cnt", 128'(s1_bub), 128'(bub[0]));
            end else begin
                chk("stall.out_valid", 128'(s0_out_valid), 128'(occ[1] > 0));
                chk("stall.in_ready", 128'(s0_in_ready), 128'(model_ready(1)));
                chk("stall.entry", 128'({s0_rdata, s0_result, s0_ctrl, s0_rd}), 128'(exp_e));
                chk("stall.bubble_cnt", 128'(s0_bub), 128'(bub[1]));
            end
        end
    endtask

    // One cycle: drive at negedge, check, then advance the model across the edge.
    task automatic step(input bit vld, input bit rdy, input bit flsh, input ent_t e);
        bit rdy_k [2];
        in_valid  = vld;
        out_ready = rdy;
        flush     = flsh;
        {in_rdata, in_result, in_ctrl, in_rd} = e;
        #1;
        check_all();
        for (int k = 0; k < 2; k++) rdy_k[k] = model_ready(k);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (occ[k] == 0 && bub[k] < CNTMAX) bub[k]++;
            if (flsh) begin
                occ[k] = 0;
            end else begin
                if (occ[k] > 0 && rdy) begin
                    fifo[k][0] = fifo[k][1];
                    occ[k]--;
                end
                if (vld && rdy_k[k]) begin
                    fifo[k][occ[k]] = e;
                    occ[k]++;
                end
            end
            if (occ[k] > 0) last[k] = fifo[k][0];
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted away from the clock edge, released a cycle later.
    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_result = 32'hDEADBEEF; in_rdata = 32'h1234_5678;
        in_ctrl = 2'b11; in_rd = 5'd7;
        model_clear();
        @(negedge clk);

        // Reset with a live upstream beat present.
        do_reset();
        chk("reset.out_result", 128'(s1_result), 128'(0));
        chk("reset.bubble_cnt", 128'(s1_bub), 128'(0));

        // Streaming 1..8 with out_ready held high: one-cycle latency, no bubbles.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 1'b0, mk(i));
            chk("stream.skid", 128'(s1_result), 128'(i));
            chk("stream.stall", 128'(s0_result), 128'(i));
        end
        step(1'b0, 1'b1, 1'b0, '0);

        // Backpressure: skid takes two and then deasserts in_ready.
        do_reset();
        step(1'b1, 1'b0, 1'b0, mk(1));
        step(1'b1, 1'b0, 1'b0, mk(2));
        chk("bp.in_ready", 128'(s1_in_ready), 128'(0));
        step(1'b1, 1'b0, 1'b0, mk(3));
        step(1'b1, 1'b1, 1'b0, mk(3));
        chk("bp.order2", 128'(s1_result), 128'(2));
        step(1'b1, 1'b1, 1'b0, mk(3));
        chk("bp.order3", 128'(s1_result), 128'(3));
        step(1'b0, 1'b1, 1'b0, '0);

        // Flush while full, with a simultaneous offer and drain.
        step(1'b1, 1'b0, 1'b0, mk(10));
        step(1'b1, 1'b0, 1'b0, mk(11));
        step(1'b1, 1'b1, 1'b1, mk(12));
        chk("flush.out_valid", 128'(s1_out_valid), 128'(0));
        chk("flush.out_ctrl", 128'(s1_ctrl), 128'(0));
        chk("flush.in_ready", 128'(s1_in_ready), 128'(1));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);

        // Idle after reset: bubble counter saturates at 15.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 1'(i % 2), 1'b0, '0);
        chk("idle.sat.skid", 128'(s1_bub), 128'(15));
        chk("idle.sat.stall", 128'(s0_bub), 128'(15));

        // Randomised traffic with occasional flush and mid-run reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 24) == 0), rnd_ent());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of each of the two data fields (memory read data, ALU result).
REQ-002 Parameter RD_W, default 5: destination-register index width.
REQ-003 Parameter CTRL_W, default 2: control field width; bit 0 = regwrite, bit 1 = MemtoReg, higher bits opaque.
REQ-004 Parameter SKID, default 1: 1 = two-entry skid stage (full throughput, registered in_ready); 0 = single-entry stall register.
REQ-005 Parameter CNT_W, default 16: width of the bubble counter.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 flush  in  1  kill all held and incoming entries this cycle.
REQ-009 in_valid  in  1  upstream entry present.
REQ-010 in_ready  out  1  stage accepts an entry this cycle.
REQ-011 in_rdata, in_result  in  DATA_W each  upstream data fields.
REQ-012 in_ctrl  in  CTRL_W  upstream control; in_rd  in  RD_W  destination index.
REQ-013 out_valid  out  1  downstream entry present; out_ready  in  1  downstream consumes.
REQ-014 out_rdata, out_result  out  DATA_W; out_ctrl  out  CTRL_W; out_rd  out  RD_W.
REQ-015 bubble_cnt  out  CNT_W  count of cycles with out_valid=0 since reset.

Function
REQ-016 Transfer in = in_valid & in_ready & !flush; transfer out = out_valid & out_ready.
REQ-017 SKID=1 uses states EMPTY, ONE (main valid), TWO (main + skid valid); out_* always driven from main.
REQ-018 EMPTY: in-transfer -> ONE, entry loaded into main.
REQ-019 ONE: in and out -> ONE, main reloaded; in only -> TWO, entry into skid; out only -> EMPTY.
REQ-020 TWO: out-transfer -> ONE, skid moves to main; no input possible.
REQ-021 SKID=1: in_ready = (state != TWO), taken from a register, no combinational path from out_ready.
REQ-022 SKID=0: one entry; in_ready = !out_valid | out_ready (combinational); simultaneous in/out reloads main.
REQ-023 Latency: entry accepted in cycle N is presented on out_* in cycle N+1 when the stage was empty.
REQ-024 Order preserved; no entry duplicated or dropped except by flush.
REQ-025 flush=1: next state EMPTY, any in_valid beat that cycle discarded; flush wins over every simultaneous event.
REQ-026 out_ctrl = stored ctrl when out_valid=1, else all zeros (bubbles never assert regwrite/MemtoReg).
REQ-027 out_rdata, out_result, out_rd hold last main value when invalid; they are not gated.
REQ-028 Held output stable: while out_valid & !out_ready, out_* unchanged.
REQ-029 bubble_cnt increments each cycle out_valid=0, saturates at all-ones, never wraps.

Reset
REQ-030 reset low asynchronously forces: state EMPTY, out_valid 0, out_ctrl 0, out_rdata 0, out_result 0, out_rd 0, skid contents 0, bubble_cnt 0, in_ready 1 (SKID=1).
REQ-031 Reset mid-operation discards all held entries; first accept allowed on first rising edge after reset rises.

Structure
REQ-032 Shared package pipe_pkg holds state enum (EMPTY/ONE/TWO), ctrl bit indices REGWRITE_BIT=0, MEMTOREG_BIT=1, default widths.
REQ-033 One sub-module pipe_entry_reg (enable-loadable register of {rdata,result,ctrl,rd} with async active-low clear), instantiated for main and skid.

Verification
REQ-034 Reset low with in_valid=1, in_result=32'hDEADBEEF -> out_valid=0, out_ctrl=0, out_result=0, bubble_cnt=0.
REQ-035 Stream 8 entries result=1..8, out_ready=1 constantly -> out_result 1..8 on 8 consecutive cycles, one cycle after each accept.
REQ-036 SKID=1, out_ready=0 while 3 entries offered -> two accepted, in_ready=0 from next cycle, third held upstream; out_ready=1 -> 1,2,3 delivered in order.
REQ-037 State TWO, flush=1 with in_valid=1, out_ready=1 -> next cycle out_valid=0, out_ctrl=2'b00, in_ready=1, none of the three entries seen again.
REQ-038 Idle with in_valid=0 for 20 cycles after reset, CNT_W=4 -> bubble_cnt saturates at 15 and stays.
REQ-039 SKID=0, out_valid=1, in_valid=1, out_ready=1 same cycle -> new entry on out_* next cycle, no bubble.
